// File: rtl/pixie_pkg.sv
// Shared constants, default geometry and the DMA state type for the Pixie display front end.
package pixie_pkg;

    localparam logic [1:0] SC_DMA = 2'b10;

    localparam int DEF_CYCLES_PER_LINE = 14;
    localparam int DEF_LINES_PER_FRAME = 262;
    localparam int DEF_FIRST_ACTIVE    = 80;
    localparam int DEF_ACTIVE_LINES    = 128;
    localparam int DEF_BYTES_PER_LINE  = 8;

    typedef enum logic {
        IDLE,
        REQ
    } dma_state_t;

    // Counter width for a range of n values; a single value still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixie_line_timer.sv
// Machine-cycle / scan-line counters with the frame_start pulse and INT/EFx line-window decode.
module pixie_line_timer
    import pixie_pkg::*;
#(
    parameter int CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int FIRST_ACTIVE    = DEF_FIRST_ACTIVE,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int MC_W            = cnt_width(DEF_CYCLES_PER_LINE),
    parameter int LINE_W          = cnt_width(DEF_LINES_PER_FRAME)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_enable,
    output logic [MC_W-1:0]   mc,
    output logic [LINE_W-1:0] line,
    output logic              mc_last,
    output logic              int_window,
    output logic              frame_start,
    output logic              efx
);

    int   line_i;
    logic line_last;
    logic ef_window;

    // Windows are compared as signed ints so small FIRST_ACTIVE values never wrap.
    always_comb begin
        line_i     = int'(line);
        mc_last    = (mc == MC_W'(CYCLES_PER_LINE - 1));
        line_last  = (line == LINE_W'(LINES_PER_FRAME - 1));
        int_window = (line_i == FIRST_ACTIVE - 2) || (line_i == FIRST_ACTIVE - 1);
        ef_window  = ((line_i >= FIRST_ACTIVE - 4) && (line_i <= FIRST_ACTIVE - 1)) ||
                     ((line_i >= FIRST_ACTIVE + ACTIVE_LINES - 4) &&
                      (line_i <= FIRST_ACTIVE + ACTIVE_LINES - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mc          <= '0;
            line        <= '0;
            frame_start <= 1'b0;
            efx         <= 1'b0;
        end else if (clk_enable) begin
            frame_start <= (mc == '0) && (line == '0);
            efx         <= ef_window;
            if (mc_last) begin
                mc   <= '0;
                line <= line_last ? '0 : line + LINE_W'(1);
            end else begin
                mc <= mc + MC_W'(1);
            end
        end
    end

endmodule

// File: rtl/pixie_dma_front_end.sv
// CDP1802 Pixie front end: display enable, per-line DMA capture into the frame buffer.
// Define PIXIE_DOUBLE_BUFFER_EN for a bank-select address MSB with tear-free bank swapping.
module pixie_dma_front_end
    import pixie_pkg::*;
#(
    parameter int CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int LINES_PER_FRAME = DEF_LINES_PER_FRAME,
    parameter int FIRST_ACTIVE    = DEF_FIRST_ACTIVE,
    parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
    parameter int BYTES_PER_LINE  = DEF_BYTES_PER_LINE,
    parameter int DMA_START       = 2,
    parameter int FB_AW           = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic [1:0]       SC,
    input  logic             disp_on,
    input  logic             disp_off,
    input  logic [7:0]       data_in,
    output logic             DMAO,
    output logic             INT,
    output logic             EFx,
`ifdef PIXIE_DOUBLE_BUFFER_EN
    output logic [FB_AW:0]   mem_addr,
`else
    output logic [FB_AW-1:0] mem_addr,
`endif
    output logic [7:0]       mem_data,
    output logic             mem_wr_en,
    output logic             frame_start,
    output logic             disp_bank
);

    localparam int MC_W   = cnt_width(CYCLES_PER_LINE);
    localparam int LINE_W = cnt_width(LINES_PER_FRAME);
    localparam int BC_W   = $clog2(BYTES_PER_LINE + 1);

    logic [MC_W-1:0]          mc;
    logic [LINE_W-1:0]        line;
    logic                     mc_last;
    logic                     int_window;
    int                       line_i;

    logic                     enable;
    logic                     line_en;
    logic                     line_en_eff;
    logic                     active;
    logic                     capture;
    logic                     last_byte;
    dma_state_t               state;
    dma_state_t               state_next;
    logic [BC_W-1:0]          byte_cnt;
    logic [BC_W-1:0]          byte_cnt_next;
    logic [LINE_W-1:0]        line_rel;
    logic [FB_AW-1:0]         wr_addr;
    logic [$bits(mem_addr)-1:0] addr_word;

    pixie_line_timer #(
        .CYCLES_PER_LINE (CYCLES_PER_LINE),
        .LINES_PER_FRAME (LINES_PER_FRAME),
        .FIRST_ACTIVE    (FIRST_ACTIVE),
        .ACTIVE_LINES    (ACTIVE_LINES),
        .MC_W            (MC_W),
        .LINE_W          (LINE_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .mc          (mc),
        .line        (line),
        .mc_last     (mc_last),
        .int_window  (int_window),
        .frame_start (frame_start),
        .efx         (EFx)
    );

    // At mc==0 the line_en register is being reloaded, so that tick already sees the new value.
    always_comb begin
        line_i        = int'(line);
        line_en_eff   = (mc == '0) ? enable : line_en;
        active        = line_en_eff && (line_i >= FIRST_ACTIVE) &&
                        (line_i < FIRST_ACTIVE + ACTIVE_LINES);
        capture       = (state == REQ) && (SC == SC_DMA);
        last_byte     = (byte_cnt == BC_W'(BYTES_PER_LINE - 1));
        line_rel      = line - LINE_W'(FIRST_ACTIVE);
        wr_addr       = FB_AW'(line_rel) * FB_AW'(BYTES_PER_LINE) + FB_AW'(byte_cnt);

        state_next    = state;
        byte_cnt_next = byte_cnt;
        case (state)
            IDLE: begin
                if ((mc == MC_W'(DMA_START)) && active) begin
                    state_next    = REQ;
                    byte_cnt_next = '0;
                end
            end
            REQ: begin
                if (capture) begin
                    byte_cnt_next = byte_cnt + BC_W'(1);
                end
                if ((capture && last_byte) || mc_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else if (clk_enable) begin
            state    <= state_next;
            byte_cnt <= byte_cnt_next;
        end
    end

`ifdef PIXIE_DOUBLE_BUFFER_EN
    logic wr_bank;
    logic frame_written;
    logic swap_point;

    assign swap_point = mc_last && (line_i == FIRST_ACTIVE + ACTIVE_LINES - 1);
    assign addr_word  = {wr_bank, wr_addr};

    // Swap as the last active line ends, but only if this frame actually delivered data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank       <= 1'b0;
            disp_bank     <= 1'b0;
            frame_written <= 1'b0;
        end else if (clk_enable) begin
            if (swap_point) begin
                frame_written <= 1'b0;
                if (frame_written || capture) begin
                    wr_bank   <= ~wr_bank;
                    disp_bank <= wr_bank;
                end
            end else if (capture) begin
                frame_written <= 1'b1;
            end
        end
    end
`else
    assign addr_word = wr_addr;
    assign disp_bank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable    <= 1'b0;
            line_en   <= 1'b0;
            DMAO      <= 1'b0;
            INT       <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            mem_data  <= '0;
        end else if (clk_enable) begin
            if (disp_off) begin
                enable <= 1'b0;
            end else if (disp_on) begin
                enable <= 1'b1;
            end
            if (mc == '0) begin
                line_en <= enable;
            end
            DMAO      <= (state_next == REQ);
            INT       <= int_window && line_en_eff;
            mem_wr_en <= capture;
            if (capture) begin
                mem_addr <= addr_word;
                mem_data <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_pixie_dma_front_end.sv
// Self-checking bench for pixie_dma_front_end: random stimulus against a tick-indexed reference
// model, a table of per-line DMA scenarios, and hand-written enable/reset sequences.
module tb_pixie_dma_front_end;

    localparam int CPL   = 14;
    localparam int LPF   = 262;
    localparam int FA    = 80;
    localparam int AL    = 128;
    localparam int BPL   = 8;
    localparam int DS    = 2;
    localparam int FB_AW = 10;
    localparam int FRAME = CPL * LPF;
`ifdef PIXIE_DOUBLE_BUFFER_EN
    localparam int AW = FB_AW + 1;
    localparam bit DB = 1'b1;
`else
    localparam int AW = FB_AW;
    localparam bit DB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clk_enable = 1'b0;
    logic [1:0]    SC = 2'b00;
    logic          disp_on = 1'b0;
    logic          disp_off = 1'b0;
    logic [7:0]    data_in = 8'h00;
    logic          DMAO, INT, EFx, mem_wr_en, frame_start, disp_bank;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;

    pixie_dma_front_end #(
        .CYCLES_PER_LINE (CPL),
        .LINES_PER_FRAME (LPF),
        .FIRST_ACTIVE    (FA),
        .ACTIVE_LINES    (AL),
        .BYTES_PER_LINE  (BPL),
        .DMA_START       (DS),
        .FB_AW           (FB_AW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .clk_enable  (clk_enable),
        .SC          (SC),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .data_in     (data_in),
        .DMAO        (DMAO),
        .INT         (INT),
        .EFx         (EFx),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_wr_en   (mem_wr_en),
        .frame_start (frame_start),
        .disp_bank   (disp_bank)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model, indexed by the absolute number of enabled ticks since reset.
    int m_t;
    bit m_en, m_len, m_req, m_wrbank, m_written;
    int m_cnt;
    bit e_dmao, e_int, e_efx, e_fs, e_wr, e_db;
    int e_addr, e_data;

    int cnt_dmao, cnt_int, cnt_efx, cnt_fs, cnt_wr;
    int wr_q[$];

    typedef struct {
        int n;
        int exp_wr;
        int exp_first;
        int exp_last;
        int exp_dmao;
    } line_vec_t;
    line_vec_t vecs[5];

    function automatic void model_reset();
        m_t = 0; m_en = 0; m_len = 0; m_req = 0; m_cnt = 0; m_wrbank = 0; m_written = 0;
        e_dmao = 0; e_int = 0; e_efx = 0; e_fs = 0; e_wr = 0; e_db = 0; e_addr = 0; e_data = 0;
    endfunction

    function automatic void model_tick(input logic [1:0] sc, input bit on, input bit off,
                                       input logic [7:0] d);
        int mc, ln;
        bit leff, act, cap;
        mc   = m_t % CPL;
        ln   = (m_t / CPL) % LPF;
        leff = (mc == 0) ? m_en : m_len;
        act  = leff && ln >= FA && ln < FA + AL;
        cap  = 0;
        e_fs  = (mc == 0) && (ln == 0);
        e_efx = (ln >= FA - 4 && ln <= FA - 1) || (ln >= FA + AL - 4 && ln <= FA + AL - 1);
        e_int = leff && (ln == FA - 2 || ln == FA - 1);
        e_wr  = 0;
        if (m_req) begin
            if (sc == 2'b10) begin
                cap    = 1;
                e_wr   = 1;
                e_addr = (ln - FA) * BPL + m_cnt + ((DB && m_wrbank) ? (1 << FB_AW) : 0);
                e_data = int'(d);
                m_cnt++;
                if (m_cnt == BPL) m_req = 0;
            end
            if (mc == CPL - 1) m_req = 0;
        end else if (mc == DS && act) begin
            m_req = 1;
            m_cnt = 0;
        end
        e_dmao = m_req;
        if (DB) begin
            if (mc == CPL - 1 && ln == FA + AL - 1) begin
                if (m_written || cap) begin
                    e_db     = m_wrbank;
                    m_wrbank = !m_wrbank;
                end
                m_written = 0;
            end else if (cap) begin
                m_written = 1;
            end
        end
        if (mc == 0) m_len = m_en;
        if (off) m_en = 0;
        else if (on) m_en = 1;
        m_t++;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        cnt_dmao = 0; cnt_int = 0; cnt_efx = 0; cnt_fs = 0; cnt_wr = 0;
        wr_q.delete();
    endtask

    // One clock with the given inputs; an enabled clock advances the model, every clock is compared.
    task automatic applyStimulus(input bit en, input logic [1:0] sc, input bit on, input bit off,
                                 input logic [7:0] d);
        logic [63:0] obs, exp;
        clk_enable = en; SC = sc; disp_on = on; disp_off = off; data_in = d;
        @(posedge clk);
        #1;
        if (en) begin
            model_tick(sc, on, off, d);
            cnt_dmao += int'(DMAO);
            cnt_int  += int'(INT);
            cnt_efx  += int'(EFx);
            cnt_fs   += int'(frame_start);
            if (mem_wr_en === 1'b1) begin
                cnt_wr++;
                wr_q.push_back(int'(mem_addr) & ((1 << FB_AW) - 1));
            end
        end
        obs = {34'd0, DMAO, INT, EFx, frame_start, mem_wr_en, disp_bank, 16'(mem_addr), mem_data};
        exp = {34'd0, e_dmao, e_int, e_efx, e_fs, e_wr, e_db, 16'(e_addr), 8'(e_data)};
        checkOutput($sformatf("outputs t=%0d", m_t), obs, exp);
        clk_enable = 1'b0; disp_on = 1'b0; disp_off = 1'b0;
    endtask

    function automatic logic [1:0] pick_sc(input bit answer);
        int v;
        if (DMAO === 1'b1) begin
            if (answer) return 2'b10;
            v = $urandom_range(0, 2);
            return (v == 2) ? 2'b11 : 2'(v);
        end
        return 2'($urandom_range(0, 3));
    endfunction

    // Randomly interleaves disabled clocks (with random strobes that must be ignored).
    task automatic step(input bit answer, input bit on, input bit off);
        if ($urandom_range(0, 3) == 0)
            applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 8'($urandom));
        applyStimulus(1'b1, pick_sc(answer), on, off, 8'($urandom));
    endtask

    task automatic run_to(input int target, input bit answer);
        while (m_t < target) step(answer, 1'b0, 1'b0);
    endtask

    task automatic step_line(input int n);
        int given;
        bit ans;
        given = 0;
        for (int k = 0; k < CPL; k++) begin
            ans = (given < n);
            if (ans && DMAO === 1'b1) given++;
            step(ans, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{n: 8,  exp_wr: 8, exp_first: 0,  exp_last: 7,  exp_dmao: 8};
        vecs[1] = '{n: 5,  exp_wr: 5, exp_first: 8,  exp_last: 12, exp_dmao: 11};
        vecs[2] = '{n: 0,  exp_wr: 0, exp_first: -1, exp_last: -1, exp_dmao: 11};
        vecs[3] = '{n: 12, exp_wr: 8, exp_first: 24, exp_last: 31, exp_dmao: 8};
        vecs[4] = '{n: 3,  exp_wr: 3, exp_first: 32, exp_last: 34, exp_dmao: 11};

        model_reset();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {58'd0, DMAO, INT, EFx, frame_start, mem_wr_en, disp_bank}, 64'd0);
        checkOutput("reset_mem", {40'd0, 16'(mem_addr), mem_data}, 64'd0);
        reset = 1'b0;

        // Frame 1: simultaneous on/off leaves the display disabled.
        step(1'b1, 1'b1, 1'b1);
        run_to(FRAME, 1'b1);
        checkOutput("off_frame_dmao", cnt_dmao, 0);
        checkOutput("off_frame_int", cnt_int, 0);
        checkOutput("off_frame_efx", cnt_efx, 8 * CPL);
        checkOutput("off_frame_fs", cnt_fs, 1);
        checkOutput("off_frame_wr", cnt_wr, 0);

        // Frame 2: enabled, CPU answers every request.
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        run_to(2 * FRAME, 1'b1);
        checkOutput("full_frame_wr", cnt_wr, 1024);
        checkOutput("full_frame_int", cnt_int, 28);
        checkOutput("full_frame_fs", cnt_fs, 1);
        checkOutput("full_frame_dmao", cnt_dmao, 1024);
        if (wr_q.size() == 1024) begin
            checkOutput("line80_first", wr_q[0], 'h000);
            checkOutput("line80_last", wr_q[7], 'h007);
            checkOutput("line207_first", wr_q[1016], 'h3F8);
            checkOutput("line207_last", wr_q[1023], 'h3FF);
        end else begin
            checkOutput("full_frame_queue", wr_q.size(), 1024);
        end
        checkOutput("bank_after_f2", disp_bank, 0);

        // Frame 3: table of per-line DMA answer counts on lines 80..84.
        run_to(2 * FRAME + FA * CPL, 1'b1);
        foreach (vecs[i]) begin
            clear_stats();
            step_line(vecs[i].n);
            checkOutput($sformatf("vec%0d_wr", i), cnt_wr, vecs[i].exp_wr);
            checkOutput($sformatf("vec%0d_dmao", i), cnt_dmao, vecs[i].exp_dmao);
            checkOutput($sformatf("vec%0d_first", i),
                        (wr_q.size() > 0) ? wr_q[0] : -1, vecs[i].exp_first);
            checkOutput($sformatf("vec%0d_last", i),
                        (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : -1, vecs[i].exp_last);
        end

        // disp_off at mc==5 of line 100: line 100 finishes, line 101 is dark.
        run_to(2 * FRAME + 100 * CPL, 1'b1);
        clear_stats();
        run_to(2 * FRAME + 100 * CPL + 5, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        run_to(2 * FRAME + 101 * CPL, 1'b1);
        checkOutput("line100_wr", cnt_wr, 8);
        if (wr_q.size() > 0) checkOutput("line100_first", wr_q[0], 20 * BPL * 8 / 8 * 1);
        clear_stats();
        run_to(2 * FRAME + 102 * CPL, 1'b1);
        checkOutput("line101_dmao", cnt_dmao, 0);
        checkOutput("line101_wr", cnt_wr, 0);
        run_to(3 * FRAME, 1'b1);
        checkOutput("bank_after_f3", disp_bank, DB ? 1 : 0);

        // Frame 4: re-enable and fill the whole frame again.
        clear_stats();
        step(1'b1, 1'b1, 1'b0);
        run_to(4 * FRAME, 1'b1);
        checkOutput("frame4_wr", cnt_wr, 1024);
        checkOutput("bank_after_f4", disp_bank, 0);

        // Reset in the middle of a DMA request on line 80 of frame 5.
        run_to(4 * FRAME + FA * CPL + 5, 1'b1);
        checkOutput("dmao_before_reset", DMAO, 1);
        clk_enable = 1'b1; SC = 2'b10;
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {58'd0, DMAO, INT, EFx, frame_start, mem_wr_en, disp_bank}, 64'd0);
        checkOutput("async_reset_mem", {40'd0, 16'(mem_addr), mem_data}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("held_reset_wr", {62'd0, mem_wr_en, DMAO}, 64'd0);
        end
        reset = 1'b0;
        clk_enable = 1'b0; SC = 2'b00;
        model_reset();
        clear_stats();
        step(1'b1, 1'b0, 1'b0);
        checkOutput("restart_frame_start", frame_start, 1);
        run_to(200, 1'b1);
        checkOutput("restart_no_dmao", cnt_dmao, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
